// File: rtl/synth_pkg.sv
// Shared synth types: note width, velocity width, allocator state encoding, note event.
// No logic here; consumed by voice_allocator and MidiProcessor.
// Optional build macro used by importers: VOICE_STEAL_EN (oldest-slot stealing).
package synth_pkg;

   localparam int NOTE_W = 7;
   localparam int VEL_W  = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      APPLY = 2'd2
   } alloc_state_t;

   typedef struct packed {
      logic              on;
      logic [NOTE_W-1:0] note;
      logic [VEL_W-1:0]  vel;
   } note_event_t;

   // A note-on carrying velocity 0 is a note-off by MIDI convention.
   function automatic logic is_note_on(input note_event_t ev);
      return ev.on && (ev.vel != '0);
   endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake between the MIDI decoder (master) and the voice allocator (slave).
// No latency; pure wiring.
// Master holds valid and payload stable until ev_ready is seen high.
interface voice_allocator_if;
   import synth_pkg::*;

   logic              ev_valid;
   logic              ev_ready;
   logic              ev_on;
   logic [NOTE_W-1:0] ev_note;
   logic [VEL_W-1:0]  ev_vel;

   modport master (output ev_valid, ev_on, ev_note, ev_vel, input ev_ready);
   modport slave  (input ev_valid, ev_on, ev_note, ev_vel, output ev_ready);

endinterface

// File: rtl/voice_slot.sv
// One voice slot: gate, note, velocity and (with VOICE_STEAL_EN) a saturating age counter.
// Updates take effect on the clock edge after commit/rel/age_inc are presented.
// No backpressure; the allocator guarantees commit and rel are never high together.
module voice_slot
   import synth_pkg::*;
`ifdef VOICE_STEAL_EN
   #(parameter int AGE_W = 8)
`endif
   (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              commit,
   input  logic              rel,
   input  logic [NOTE_W-1:0] set_note,
   input  logic [VEL_W-1:0]  set_vel,
`ifdef VOICE_STEAL_EN
   input  logic              age_inc,
   output logic [AGE_W-1:0]  age,
`endif
   output logic              gate,
   output logic [NOTE_W-1:0] note,
   output logic [VEL_W-1:0]  vel
);

   // Commit loads a new note and opens the gate; release only closes the gate so
   // note and velocity stay valid for the envelope's release phase.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gate <= 1'b0;
         note <= '0;
         vel  <= '0;
      end else if (commit) begin
         gate <= 1'b1;
         note <= set_note;
         vel  <= set_vel;
      end else if (rel) begin
         gate <= 1'b0;
      end
   end

`ifdef VOICE_STEAL_EN
   // Age restarts on commit and otherwise counts commits elsewhere, saturating.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         age <= '0;
      end else if (commit) begin
         age <= '0;
      end else if (age_inc && (age != '1)) begin
         age <= age + 1'b1;
      end
   end
`endif

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: match-retrigger, else lowest free slot, else (VOICE_STEAL_EN) steal oldest.
// Latency: event accepted at t, slot outputs and trig/steal/drop pulses visible at t+NUM_VOICES+2.
// Backpressure: ev_ready is high only in IDLE (and not in reset); one event per NUM_VOICES+2 cycles.
module voice_allocator
   import synth_pkg::*;
   #(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 8
   ) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   voice_allocator_if.slave             ev,
   output logic [NUM_VOICES-1:0]        o_voice_gate,
   output logic [NOTE_W*NUM_VOICES-1:0] o_voice_note,
   output logic [VEL_W*NUM_VOICES-1:0]  o_voice_vel,
   output logic [NUM_VOICES-1:0]        o_voice_trig,
   output logic                         o_steal,
   output logic                         o_drop
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_SCAN  = SCAN;
   localparam logic [1:0] ST_APPLY = APPLY;

   if ((NUM_VOICES < 2) || (NUM_VOICES > 16) || (AGE_W < 1)) begin : g_bad_params
      $error("voice_allocator: NUM_VOICES must be 2..16 and AGE_W at least 1");
   end

   logic [1:0]       state;
   logic [IDX_W-1:0] scan_idx;
   note_event_t      ev_q;
   logic             accept;

   logic             match_vld;
   logic [IDX_W-1:0] match_idx;
   logic             free_vld;
   logic [IDX_W-1:0] free_idx;

   logic [NUM_VOICES-1:0] slot_gate;
   logic [NOTE_W-1:0]     slot_note [NUM_VOICES];
   logic [VEL_W-1:0]      slot_vel  [NUM_VOICES];

   logic [NUM_VOICES-1:0] commit_vec;
   logic [NUM_VOICES-1:0] rel_vec;
   logic                  drop_now;

`ifdef VOICE_STEAL_EN
   logic                  old_vld;
   logic [IDX_W-1:0]      old_idx;
   logic [AGE_W-1:0]      old_age;
   logic [AGE_W-1:0]      slot_age [NUM_VOICES];
   logic [NUM_VOICES-1:0] age_inc_vec;
   logic                  steal_now;
`endif

   assign ev.ev_ready = (state == ST_IDLE) && !i_rst;
   assign accept      = ev.ev_valid && ev.ev_ready;

   // Sequencer: latch the event on acceptance, walk every slot once, then commit for one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         scan_idx <= '0;
         ev_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state    <= ST_SCAN;
                  scan_idx <= '0;
                  ev_q     <= '{on: ev.ev_on, note: ev.ev_note, vel: ev.ev_vel};
               end
            end
            ST_SCAN: begin
               if (scan_idx == LAST_IDX) begin
                  state <= ST_APPLY;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            ST_APPLY: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Candidate search: first same-note gated slot, first ungated slot and oldest gated slot.
   // Strict '>' keeps the lowest index on an age tie because slots are visited in ascending order.
   always_ff @(posedge i_clk) begin
      if (i_rst || accept) begin
         match_vld <= 1'b0;
         match_idx <= '0;
         free_vld  <= 1'b0;
         free_idx  <= '0;
`ifdef VOICE_STEAL_EN
         old_vld   <= 1'b0;
         old_idx   <= '0;
         old_age   <= '0;
`endif
      end else if (state == ST_SCAN) begin
         if (!match_vld && slot_gate[scan_idx] && (slot_note[scan_idx] == ev_q.note)) begin
            match_vld <= 1'b1;
            match_idx <= scan_idx;
         end
         if (!free_vld && !slot_gate[scan_idx]) begin
            free_vld <= 1'b1;
            free_idx <= scan_idx;
         end
`ifdef VOICE_STEAL_EN
         if (slot_gate[scan_idx] && (!old_vld || (slot_age[scan_idx] > old_age))) begin
            old_vld <= 1'b1;
            old_idx <= scan_idx;
            old_age <= slot_age[scan_idx];
         end
`endif
      end
   end

   // Decision for the APPLY cycle: which slot commits, which slots release, and pulse causes.
   always_comb begin
      commit_vec = '0;
      rel_vec    = '0;
      drop_now   = 1'b0;
`ifdef VOICE_STEAL_EN
      age_inc_vec = '0;
      steal_now   = 1'b0;
`endif
      if (state == ST_APPLY) begin
         if (is_note_on(ev_q)) begin
            if (match_vld) begin
               commit_vec[match_idx] = 1'b1;
            end else if (free_vld) begin
               commit_vec[free_idx] = 1'b1;
`ifdef VOICE_STEAL_EN
            end else if (old_vld) begin
               commit_vec[old_idx] = 1'b1;
               steal_now           = 1'b1;
`endif
            end else begin
               drop_now = 1'b1;
            end
`ifdef VOICE_STEAL_EN
            if (|commit_vec) begin
               age_inc_vec = slot_gate & ~commit_vec;
            end
`endif
         end else begin
            for (int k = 0; k < NUM_VOICES; k++) begin
               rel_vec[k] = slot_gate[k] && (slot_note[k] == ev_q.note);
            end
            drop_now = (rel_vec == '0);
         end
      end
   end

   // Single-cycle pulses registered alongside the slot update so they line up with it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_voice_trig <= '0;
         o_drop       <= 1'b0;
      end else begin
         o_voice_trig <= commit_vec;
         o_drop       <= drop_now;
      end
   end

`ifdef VOICE_STEAL_EN
   // Steal pulse follows the commit that evicted a gated slot.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_steal <= 1'b0;
      end else begin
         o_steal <= steal_now;
      end
   end
`else
   assign o_steal = 1'b0;
`endif

   for (genvar k = 0; k < NUM_VOICES; k++) begin : g_slot
      voice_slot
`ifdef VOICE_STEAL_EN
         #(.AGE_W(AGE_W))
`endif
         u_slot (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .commit   (commit_vec[k]),
         .rel      (rel_vec[k]),
         .set_note (ev_q.note),
         .set_vel  (ev_q.vel),
`ifdef VOICE_STEAL_EN
         .age_inc  (age_inc_vec[k]),
         .age      (slot_age[k]),
`endif
         .gate     (slot_gate[k]),
         .note     (slot_note[k]),
         .vel      (slot_vel[k])
      );

      assign o_voice_note[NOTE_W*k +: NOTE_W] = slot_note[k];
      assign o_voice_vel[VEL_W*k +: VEL_W]    = slot_vel[k];
   end

   assign o_voice_gate = slot_gate;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator at default parameters (4 voices).
// Directed scenarios plus randomized events against a slot/timestamp reference model.
// Expectations follow VOICE_STEAL_EN when it is defined for the build.
module tb_voice_allocator;

   localparam int NV = 4;

   logic            clk;
   logic            rst;
   logic [NV-1:0]   gate;
   logic [7*NV-1:0] vnote;
   logic [7*NV-1:0] vvel;
   logic [NV-1:0]   trig;
   logic            steal;
   logic            drop;

   int vectors;
   int miscompares;

   voice_allocator_if bus ();

   voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .ev           (bus),
      .o_voice_gate (gate),
      .o_voice_note (vnote),
      .o_voice_vel  (vvel),
      .o_voice_trig (trig),
      .o_steal      (steal),
      .o_drop       (drop)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   initial begin
      #(40 * 40000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model: slot contents plus commit timestamps ----------------
   bit        m_gate  [NV];
   bit [6:0]  m_note  [NV];
   bit [6:0]  m_vel   [NV];
   int        m_stamp [NV];
   int        m_seq;
   logic [NV-1:0] exp_trig;
   logic          exp_steal;
   logic          exp_drop;

   task automatic model_reset();
      for (int k = 0; k < NV; k++) begin
         m_gate[k] = 0; m_note[k] = '0; m_vel[k] = '0; m_stamp[k] = 0;
      end
      m_seq = 0;
   endtask

   task automatic model_event(input logic on, input logic [6:0] note, input logic [6:0] vel);
      int sel;
      bit any;
      sel = -1;
      any = 0;
      exp_trig = '0; exp_steal = 1'b0; exp_drop = 1'b0;
      if (on && vel != 0) begin
         for (int k = 0; k < NV; k++) if (sel < 0 && m_gate[k] && m_note[k] == note) sel = k;
         for (int k = 0; k < NV; k++) if (sel < 0 && !m_gate[k]) sel = k;
`ifdef VOICE_STEAL_EN
         if (sel < 0) begin
            sel = 0;
            for (int k = 1; k < NV; k++) if (m_stamp[k] < m_stamp[sel]) sel = k;
            exp_steal = 1'b1;
         end
`endif
         if (sel < 0) begin
            exp_drop = 1'b1;
         end else begin
            m_gate[sel] = 1; m_note[sel] = note; m_vel[sel] = vel;
            m_stamp[sel] = m_seq; m_seq++;
            exp_trig[sel] = 1'b1;
         end
      end else begin
         for (int k = 0; k < NV; k++) begin
            if (m_gate[k] && m_note[k] == note) begin
               m_gate[k] = 0; any = 1;
            end
         end
         exp_drop = !any;
      end
   endtask

   // ---------------- stimulus driver (observes, does not judge) ----------------
   logic [NV-1:0] obs_trig;
   logic          obs_steal, obs_drop, obs_ready;
   logic          early_pulse, early_ready, post_pulse;
   bit            accept_timeout;

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Presents one event, waits for acceptance at cycle t, captures t+1..t+5, t+6 and t+7.
   task automatic run_event(input logic on, input logic [6:0] note, input logic [6:0] vel);
      int n;
      @(negedge clk);
      bus.ev_valid = 1'b1; bus.ev_on = on; bus.ev_note = note; bus.ev_vel = vel;
      n = 0;
      accept_timeout = 0;
      while (bus.ev_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         accept_timeout = 1;
         bus.ev_valid = 1'b0;
         return;
      end
      early_pulse = 1'b0;
      early_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) bus.ev_valid = 1'b0;
         early_pulse |= (|trig) | steal | drop;
         early_ready |= bus.ev_ready;
      end
      @(negedge clk);
      obs_trig = trig; obs_steal = steal; obs_drop = drop; obs_ready = bus.ev_ready;
      @(negedge clk);
      post_pulse = (|trig) | steal | drop;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if (bus.ev_ready !== 1'b0) begin
         $display("FAIL reset_ready_low: got %b want 0", bus.ev_ready); miscompares++;
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (bus.ev_ready !== 1'b1) begin
         $display("FAIL reset_ready_after: got %b want 1", bus.ev_ready); miscompares++;
      end
      vectors++;
      if (gate !== '0 || vnote !== '0 || vvel !== '0 || trig !== '0 || steal !== 1'b0 || drop !== 1'b0) begin
         $display("FAIL reset_outputs: gate=%h note=%h vel=%h trig=%h steal=%b drop=%b want all 0",
                  gate, vnote, vvel, trig, steal, drop);
         miscompares++;
      end
   endtask

   task automatic test_first_note();
      logic [6:0] n0, v0;
      pulse_reset();
      run_event(1'b1, 7'd60, 7'd100);
      vectors++;
      if (accept_timeout || early_pulse || early_ready || obs_ready !== 1'b1) begin
         $display("FAIL first_timing: timeout=%0d early_pulse=%b early_ready=%b ready@t+6=%b want 0 0 0 1",
                  accept_timeout, early_pulse, early_ready, obs_ready);
         miscompares++;
      end
      vectors++;
      if (obs_trig !== 4'b0001 || post_pulse !== 1'b0) begin
         $display("FAIL first_trig: trig@t+6=%b post=%b want 0001 0", obs_trig, post_pulse); miscompares++;
      end
      n0 = vnote[6:0];
      v0 = vvel[6:0];
      vectors++;
      if (gate !== 4'b0001 || n0 !== 7'd60 || v0 !== 7'd100) begin
         $display("FAIL first_slot0: gate=%b note=%0d vel=%0d want 0001 60 100", gate, n0, v0); miscompares++;
      end
   endtask

   task automatic test_steal();
      logic [27:0] want_note;
      pulse_reset();
      run_event(1'b1, 7'd60, 7'd10);
      run_event(1'b1, 7'd62, 7'd20);
      run_event(1'b1, 7'd64, 7'd30);
      run_event(1'b1, 7'd67, 7'd40);
      run_event(1'b1, 7'd69, 7'd50);
`ifdef VOICE_STEAL_EN
      want_note = {7'd67, 7'd64, 7'd62, 7'd69};
      vectors++;
      if (obs_trig !== 4'b0001 || obs_steal !== 1'b1 || obs_drop !== 1'b0) begin
         $display("FAIL steal_pulses: trig=%b steal=%b drop=%b want 0001 1 0", obs_trig, obs_steal, obs_drop);
         miscompares++;
      end
`else
      want_note = {7'd67, 7'd64, 7'd62, 7'd60};
      vectors++;
      if (obs_trig !== 4'b0000 || obs_steal !== 1'b0 || obs_drop !== 1'b1) begin
         $display("FAIL full_drop_pulses: trig=%b steal=%b drop=%b want 0000 0 1", obs_trig, obs_steal, obs_drop);
         miscompares++;
      end
`endif
      vectors++;
      if (vnote !== want_note || gate !== 4'b1111) begin
         $display("FAIL full_slots: notes=%h gate=%b want %h 1111", vnote, gate, want_note); miscompares++;
      end
   endtask

   task automatic test_retrigger();
      int trig_count;
      pulse_reset();
      trig_count = 0;
      run_event(1'b1, 7'd60, 7'd100);
      if (obs_trig === 4'b0001) trig_count++;
      run_event(1'b1, 7'd60, 7'd77);
      if (obs_trig === 4'b0001) trig_count++;
      vectors++;
      if (trig_count != 2 || gate !== 4'b0001 || vvel[6:0] !== 7'd77) begin
         $display("FAIL retrigger: trig0 count=%0d gate=%b vel0=%0d want 2 0001 77", trig_count, gate, vvel[6:0]);
         miscompares++;
      end
   endtask

   task automatic test_vel0_off();
      pulse_reset();
      run_event(1'b1, 7'd60, 7'd100);
      run_event(1'b1, 7'd60, 7'd0);
      vectors++;
      if (obs_trig !== 4'b0000 || obs_drop !== 1'b0 || gate !== 4'b0000 ||
          vnote[6:0] !== 7'd60 || vvel[6:0] !== 7'd100) begin
         $display("FAIL vel0_off: trig=%b drop=%b gate=%b note0=%0d vel0=%0d want 0000 0 0000 60 100",
                  obs_trig, obs_drop, gate, vnote[6:0], vvel[6:0]);
         miscompares++;
      end
   endtask

   task automatic test_drop_off();
      pulse_reset();
      run_event(1'b0, 7'd50, 7'd64);
      vectors++;
      if (obs_drop !== 1'b1 || post_pulse !== 1'b0 || early_pulse !== 1'b0 || gate !== 4'b0000) begin
         $display("FAIL drop_off: drop@t+6=%b post=%b early=%b gate=%b want 1 0 0 0000",
                  obs_drop, post_pulse, early_pulse, gate);
         miscompares++;
      end
   endtask

   task automatic test_reset_mid_scan();
      logic seen_trig;
      pulse_reset();
      @(negedge clk);
      bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_note = 7'd60; bus.ev_vel = 7'd90;
      @(negedge clk);
      bus.ev_valid = 1'b0;
      seen_trig = |trig;
      @(negedge clk);
      rst = 1'b1;
      seen_trig |= |trig;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (bus.ev_ready !== 1'b1 || gate !== '0 || vnote !== '0 || vvel !== '0 || steal !== 1'b0 || drop !== 1'b0) begin
         $display("FAIL midscan_reset: ready=%b gate=%b note=%h vel=%h steal=%b drop=%b want 1 and zeros",
                  bus.ev_ready, gate, vnote, vvel, steal, drop);
         miscompares++;
      end
      for (int i = 0; i < 10; i++) begin
         seen_trig |= |trig;
         @(negedge clk);
      end
      vectors++;
      if (seen_trig !== 1'b0 || gate !== '0) begin
         $display("FAIL midscan_no_trig: seen trig=%b gate=%b want 0 0000", seen_trig, gate); miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      @(negedge clk);
      bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_note = 7'd60; bus.ev_vel = 7'd100;
      @(negedge clk);
      bus.ev_note = 7'd62; bus.ev_vel = 7'd50;
      for (int i = 2; i <= 6; i++) @(negedge clk);
      vectors++;
      if (trig !== 4'b0001 || bus.ev_ready !== 1'b1) begin
         $display("FAIL b2b_first: trig=%b ready=%b want 0001 1", trig, bus.ev_ready); miscompares++;
      end
      @(negedge clk);
      bus.ev_valid = 1'b0;
      for (int i = 8; i <= 12; i++) @(negedge clk);
      vectors++;
      if (trig !== 4'b0010 || gate !== 4'b0011 || vnote[13:7] !== 7'd62 || vvel[13:7] !== 7'd50) begin
         $display("FAIL b2b_second: trig=%b gate=%b note1=%0d vel1=%0d want 0010 0011 62 50",
                  trig, gate, vnote[13:7], vvel[13:7]);
         miscompares++;
      end
   endtask

   task automatic test_random();
      logic        on;
      logic [6:0]  note, vel;
      logic [27:0] e_note, e_vel;
      logic [3:0]  e_gate;
      pulse_reset();
      for (int i = 0; i < 150; i++) begin
         on   = ($urandom_range(0, 99) < 65);
         note = 7'(60 + $urandom_range(0, 5));
         vel  = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         run_event(on, note, vel);
         model_event(on, note, vel);
         for (int k = 0; k < NV; k++) begin
            e_gate[k] = m_gate[k];
            e_note[7*k +: 7] = m_note[k];
            e_vel[7*k +: 7]  = m_vel[k];
         end
         vectors++;
         if (accept_timeout || early_pulse || early_ready || obs_ready !== 1'b1 || post_pulse !== 1'b0) begin
            $display("FAIL rand_timing[%0d]: timeout=%0d early=%b early_ready=%b ready=%b post=%b",
                     i, accept_timeout, early_pulse, early_ready, obs_ready, post_pulse);
            miscompares++;
         end
         vectors++;
         if (obs_trig !== exp_trig || obs_steal !== exp_steal || obs_drop !== exp_drop) begin
            $display("FAIL rand_pulses[%0d] on=%b note=%0d vel=%0d: trig=%b steal=%b drop=%b want %b %b %b",
                     i, on, note, vel, obs_trig, obs_steal, obs_drop, exp_trig, exp_steal, exp_drop);
            miscompares++;
         end
         vectors++;
         if (gate !== e_gate || vnote !== e_note || vvel !== e_vel) begin
            $display("FAIL rand_slots[%0d]: gate=%b note=%h vel=%h want %b %h %h",
                     i, gate, vnote, vvel, e_gate, e_note, e_vel);
            miscompares++;
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      bus.ev_valid = 1'b0; bus.ev_on = 1'b0; bus.ev_note = '0; bus.ev_vel = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      test_reset();
      test_first_note();
      test_steal();
      test_retrigger();
      test_vel0_off();
      test_drop_off();
      test_reset_mid_scan();
      test_back_to_back();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
